gcn_coo_aggregate_argmax: RTL

- Parametrised successor to the fixed 6-node GCN aggregation/argmax stage.
- Takes a preloaded FM×WM product matrix (nodes × classes) and walks a COO edge list one edge per cycle.
- Accumulates each neighbour's product row into the destination node's row, then computes a per-node argmax class index.
- Sits between the FM×WM dot-product engine and the top-level max_addi_answer output; the COO memory lives outside the block.

---
 rtl/gcn_coo_aggregate_argmax.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gcn_coo_aggregate_argmax.sv
// GCN aggregation stage: walks a COO edge list summing neighbour product rows, then argmax per node.
// Optional GCN_SYMMETRIC_EN: each valid edge also feeds dst's product row back into src.
module gcn_coo_aggregate_argmax #(
  parameter int unsigned NUM_OF_NODES      = 6,
  parameter int unsigned NUM_OF_EDGES      = 6,
  parameter int unsigned NUM_CLASSES       = 3,
  parameter int unsigned DOT_PROD_WIDTH    = 16,
  parameter int unsigned ACC_WIDTH         = 20,
  parameter int unsigned SELF_LOOP         = 1,
  parameter int unsigned NODE_BW           = $clog2(NUM_OF_NODES),
  parameter int unsigned EDGE_BW           = $clog2(NUM_OF_EDGES),
  parameter int unsigned MAX_ADDRESS_WIDTH = $clog2(NUM_CLASSES)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic                                          prod_we,
  input  logic [NODE_BW-1:0]                            prod_row,
  input  logic [NUM_CLASSES*DOT_PROD_WIDTH-1:0]         prod_data,
  output logic [EDGE_BW-1:0]                            coo_address,
  input  logic [2*NODE_BW-1:0]                          coo_in,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          err_edge,
  output logic [0:NUM_OF_NODES-1][MAX_ADDRESS_WIDTH-1:0] max_addi_answer
);

`ifdef GCN_SYMMETRIC_EN
  localparam bit Symmetric = 1'b1;
`else
  localparam bit Symmetric = 1'b0;
`endif

  localparam logic [ACC_WIDTH-1:0] AccMax   = '1;
  localparam logic [NODE_BW:0]     NumNodes = (NODE_BW+1)'(NUM_OF_NODES);
  localparam logic [EDGE_BW-1:0]   LastEdge = EDGE_BW'(NUM_OF_EDGES - 1);
  localparam logic [NODE_BW-1:0]   LastNode = NODE_BW'(NUM_OF_NODES - 1);

  typedef enum logic [2:0] {StIdle, StClear, StEdge, StArgmax, StDone} state_e;

  state_e                 state_q, state_d;
  logic [EDGE_BW-1:0]     edge_q, edge_d;
  logic [NODE_BW-1:0]     node_q, node_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [0:NUM_OF_NODES-1][MAX_ADDRESS_WIDTH-1:0] ans_q, ans_d;

  logic [DOT_PROD_WIDTH-1:0] prod_q [NUM_OF_NODES][NUM_CLASSES];
  logic [ACC_WIDTH-1:0]      acc_q  [NUM_OF_NODES][NUM_CLASSES];
  logic [ACC_WIDTH-1:0]      acc_d  [NUM_OF_NODES][NUM_CLASSES];

  logic [NODE_BW-1:0]           src, dst;
  logic                         edge_ok;
  logic [ACC_WIDTH-1:0]         best_val;
  logic [MAX_ADDRESS_WIDTH-1:0] best_idx;

  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0]      a,
                                                   input logic [DOT_PROD_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] sum;
    sum = {1'b0, a} + (ACC_WIDTH+1)'(b);
    return sum[ACC_WIDTH] ? AccMax : sum[ACC_WIDTH-1:0];
  endfunction

  assign src         = coo_in[2*NODE_BW-1:NODE_BW];
  assign dst         = coo_in[NODE_BW-1:0];
  assign edge_ok     = ({1'b0, src} < NumNodes) && ({1'b0, dst} < NumNodes);
  assign busy        = (state_q == StClear) || (state_q == StEdge) || (state_q == StArgmax);
  assign done        = done_q;
  assign err_edge    = err_q;
  assign coo_address = edge_q;
  assign max_addi_answer = ans_q;

  // Strict '>' keeps the lowest class index on ties.
  always_comb begin
    best_idx = '0;
    best_val = acc_q[node_q][0];
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (acc_q[node_q][c] > best_val) begin
        best_val = acc_q[node_q][c];
        best_idx = MAX_ADDRESS_WIDTH'(c);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    node_d  = node_q;
    err_d   = err_q;
    ans_d   = ans_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        done_d = (state_q == StDone);
        if (start) begin
          state_d = StClear;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StClear: begin
        for (int n = 0; n < NUM_OF_NODES; n++) begin
          for (int c = 0; c < NUM_CLASSES; c++) begin
            acc_d[n][c] = (SELF_LOOP != 0) ? ACC_WIDTH'(prod_q[n][c]) : '0;
          end
        end
        edge_d  = '0;
        state_d = StEdge;
      end
      StEdge: begin
        if (edge_ok) begin
          for (int c = 0; c < NUM_CLASSES; c++) begin
            acc_d[dst][c] = sat_add(acc_q[dst][c], prod_q[src][c]);
            // A self edge must be counted once, so the reverse add is skipped.
            if (Symmetric && (src != dst)) begin
              acc_d[src][c] = sat_add(acc_q[src][c], prod_q[dst][c]);
            end
          end
        end else begin
          err_d = 1'b1;
        end
        if (edge_q == LastEdge) begin
          edge_d  = '0;
          node_d  = '0;
          state_d = StArgmax;
        end else begin
          edge_d = edge_q + 1'b1;
        end
      end
      StArgmax: begin
        ans_d[node_q] = best_idx;
        if (node_q == LastNode) begin
          node_d  = '0;
          state_d = StDone;
        end else begin
          node_d = node_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      edge_q  <= '0;
      node_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ans_q   <= '0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      node_q  <= node_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ans_q   <= ans_d;
    end
  end

  // Datapath storage carries no reset; contents are rebuilt by CLEAR or host writes.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    if (prod_we && !busy && ({1'b0, prod_row} < NumNodes)) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        prod_q[prod_row][c] <= prod_data[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
      end
    end
  end

endmodule
